mem_arbiter: RTL and testbench

- Shares the single physical memory port of the RV32I core between an instruction-fetch requester (I-side, read-only) and a data requester (D-side, read/write).
- Sits between the split I/D caches (or fetch/LSU logic) and the memory model.
- Latches one request at a time, holds it stable downstream until mem_resp, and routes the response back to the granted side.
- Ties are broken round-robin, and a watchdog flags hung transactions.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter for the RV32I core. It shares one downstream port between
// instruction fetch and data access, uses round-robin for ties and has a watchdog for hung transactions.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byte_enable,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TMO_LIMIT = TIMEOUT_CYCLES[CNT_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                 WDG_EN    = (TIMEOUT_CYCLES != 32'd0);

    state_t               state_r;
    state_t               state_s;
    logic                 last_d_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 timeout_r;
    logic                 mem_read_r;
    logic                 mem_write_r;
    logic [3:0]           mem_be_r;
    logic [31:0]          mem_addr_r;
    logic [31:0]          mem_wdata_r;
    logic                 d_req_s;
    logic                 grant_i_s;
    logic                 grant_d_s;
    logic                 done_s;
    logic                 serving_s;
    logic                 stall_s;

    // Arbitration and next-state decode
    always_comb begin
        state_s   = state_r;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        done_s    = 1'b0;
        serving_s = 1'b0;
        d_req_s   = d_read | d_write;
        case (state_r)
            IDLE: begin
                // On a tie, D wins unless D was the side served last.
                if (d_req_s && (!i_read || !last_d_r)) begin
                    grant_d_s = 1'b1;
                    state_s   = SERVE_D;
                end else if (i_read) begin
                    grant_i_s = 1'b1;
                    state_s   = SERVE_I;
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                serving_s = 1'b1;
                if (mem_resp) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                done_s  = 1'b1;
                state_s = IDLE;
            end
        endcase
        stall_s = serving_s & ~mem_resp;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Downstream request latch, held for the whole transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            last_d_r    <= 1'b0;
        end else if (grant_i_s) begin
            mem_read_r  <= 1'b1;
            mem_write_r <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= i_address;
            mem_wdata_r <= 32'h0000_0000;
            last_d_r    <= 1'b0;
        end else if (grant_d_s) begin
            // A simultaneous read+write request is issued as a write.
            mem_read_r  <= ~d_write;
            mem_write_r <= d_write;
            mem_be_r    <= d_byte_enable;
            mem_addr_r  <= d_address;
            mem_wdata_r <= d_wdata;
            last_d_r    <= 1'b1;
        end else if (done_s) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            mem_read_r  <= mem_read_r;
            mem_write_r <= mem_write_r;
        end
    end

    // Watchdog: counts stalled cycles, saturates at the limit, flag is sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= {CNT_WIDTH{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (grant_i_s || grant_d_s) begin
                cnt_r <= {CNT_WIDTH{1'b0}};
            end else if (stall_s && (cnt_r != TMO_LIMIT)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (WDG_EN && stall_s && (cnt_r == (TMO_LIMIT - CNT_ONE))) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    // Responses pass straight through to the granted side only
    assign i_resp          = (state_r == SERVE_I) & mem_resp;
    assign d_resp          = (state_r == SERVE_D) & mem_resp;
    assign i_rdata         = i_resp ? mem_rdata : 32'h0000_0000;
    assign d_rdata         = d_resp ? mem_rdata : 32'h0000_0000;
    assign busy            = serving_s;
    assign timeout_err     = timeout_r;
    assign mem_read        = mem_read_r;
    assign mem_write       = mem_write_r;
    assign mem_byte_enable = mem_be_r;
    assign mem_address     = mem_addr_r;
    assign mem_wdata       = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rb;
        logic        ir;
        logic        dr;
        logic        dw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        mr;
        logic [31:0] mrd;
        logic        e_mr;
        logic        e_mw;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_ir;
        logic        e_dr;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_mr, input logic e_mw,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_wd, input logic e_ir, input logic e_dr,
                             input logic [31:0] rd, input logic e_busy, input logic e_to);
        chk({tag, ".mem_read"},  {31'd0, mem_read},  {31'd0, e_mr});
        chk({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, e_mw});
        if (e_mr || e_mw) begin
            chk({tag, ".mem_address"}, mem_address, e_addr);
            chk({tag, ".mem_be"}, {28'd0, mem_byte_enable}, {28'd0, e_be});
            chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
        end
        chk({tag, ".i_resp"},  {31'd0, i_resp}, {31'd0, e_ir});
        chk({tag, ".d_resp"},  {31'd0, d_resp}, {31'd0, e_dr});
        chk({tag, ".i_rdata"}, i_rdata, e_ir ? rd : 32'h0000_0000);
        chk({tag, ".d_rdata"}, d_rdata, e_dr ? rd : 32'h0000_0000);
        chk({tag, ".busy"},    {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".timeout"}, {31'd0, timeout_err}, {31'd0, e_to});
    endtask

    function automatic void add(input logic rb, input logic ir, input logic dr, input logic dw,
                                input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                                input logic [3:0] dbe, input logic mr, input logic [31:0] mrd,
                                input logic e_mr, input logic e_mw, input logic [31:0] e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wd,
                                input logic e_ir, input logic e_dr, input logic e_busy);
        tbl.push_back('{rb, ir, dr, dw, ia, da, dwd, dbe, mr, mrd,
                        e_mr, e_mw, e_addr, e_be, e_wd, e_ir, e_dr, e_busy});
    endfunction

    task automatic clear_inputs();
        i_read = 1'b0; i_address = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_byte_enable = 4'h0; d_address = 32'h0; d_wdata = 32'h0;
        mem_resp = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reference model state for the random phase
    int          owner;
    logic        last_was_d;
    logic        m_wr;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    int          waited;
    logic        m_to;
    int          lat;
    logic        i_drop;
    logic        d_drop;
    int          side;

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check_all("reset", 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset.mem_address", mem_address, 32'h0);
        chk("reset.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;

        // T1: lone I read; T2: D write; T3: ties after reset alternate D,I,D,I; spurious mem_resp in IDLE
        add(1'b0,1'b1,1'b0,1'b0,32'h60,32'h0,32'h0,4'h0,1'b0,32'h0,          1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,32'h60,32'h0,32'h0,4'h0,1'b0,32'h0,          1'b1,1'b0,32'h60,4'h0,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,1'b0,32'h60,32'h0,32'h0,4'h0,1'b0,32'h0,          1'b1,1'b0,32'h60,4'h0,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,1'b0,32'h60,32'h0,32'h0,4'h0,1'b0,32'h0,          1'b1,1'b0,32'h60,4'h0,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,1'b0,32'h60,32'h0,32'h0,4'h0,1'b1,32'h0051_3093,  1'b1,1'b0,32'h60,4'h0,32'h0,1'b1,1'b0,1'b1);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,4'h0,1'b0,32'h0,           1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,32'h100,32'hDEAD_BEEF,4'h3,1'b0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,32'h100,32'hDEAD_BEEF,4'h3,1'b0,32'h0, 1'b0,1'b1,32'h100,4'h3,32'hDEAD_BEEF,1'b0,1'b0,1'b1);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,32'h100,32'hDEAD_BEEF,4'h3,1'b1,32'h1234, 1'b0,1'b1,32'h100,4'h3,32'hDEAD_BEEF,1'b0,1'b1,1'b1);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,4'h0,1'b0,32'h0,           1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b1,1'b0,32'h80,32'h200,32'h0,4'hF,1'b0,32'h0,        1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,32'h80,32'h200,32'h0,4'hF,1'b0,32'h0,        1'b1,1'b0,32'h200,4'hF,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,1'b0,32'h80,32'h200,32'h0,4'hF,1'b1,32'hAAAA_0001, 1'b1,1'b0,32'h200,4'hF,32'h0,1'b0,1'b1,1'b1);
        add(1'b0,1'b1,1'b0,1'b0,32'h80,32'h200,32'h0,4'hF,1'b0,32'h0,        1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,1'b0,32'h80,32'h200,32'h0,4'hF,1'b0,32'h0,        1'b1,1'b0,32'h80,4'h0,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b0,1'b0,32'h80,32'h200,32'h0,4'hF,1'b1,32'hBBBB_0002, 1'b1,1'b0,32'h80,4'h0,32'h0,1'b1,1'b0,1'b1);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,4'h0,1'b0,32'h0,           1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,32'h84,32'h204,32'h0,4'hF,1'b0,32'h0,        1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,32'h84,32'h204,32'h0,4'hF,1'b0,32'h0,        1'b1,1'b0,32'h204,4'hF,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,1'b0,32'h84,32'h204,32'h0,4'hF,1'b1,32'hCCCC_0003, 1'b1,1'b0,32'h204,4'hF,32'h0,1'b0,1'b1,1'b1);
        add(1'b0,1'b1,1'b1,1'b0,32'h84,32'h208,32'h0,4'hF,1'b0,32'h0,        1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,32'h84,32'h208,32'h0,4'hF,1'b0,32'h0,        1'b1,1'b0,32'h84,4'h0,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,1'b0,32'h84,32'h208,32'h0,4'hF,1'b1,32'hDDDD_0004, 1'b1,1'b0,32'h84,4'h0,32'h0,1'b1,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,1'b0,32'h88,32'h208,32'h0,4'hF,1'b0,32'h0,        1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b1,1'b0,32'h88,32'h208,32'h0,4'hF,1'b0,32'h0,        1'b1,1'b0,32'h208,4'hF,32'h0,1'b0,1'b0,1'b1);
        add(1'b0,1'b1,1'b1,1'b0,32'h88,32'h208,32'h0,4'hF,1'b1,32'hEEEE_0005, 1'b1,1'b0,32'h208,4'hF,32'h0,1'b0,1'b1,1'b1);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,4'h0,1'b1,32'hFFFF_0006,   1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,4'h0,1'b0,32'h0,           1'b0,1'b0,32'h0,4'h0,32'h0,1'b0,1'b0,1'b0);

        foreach (tbl[n]) begin
            if (tbl[n].rb) do_reset();
            @(posedge clk); #1;
            i_read = tbl[n].ir; i_address = tbl[n].ia;
            d_read = tbl[n].dr; d_write = tbl[n].dw; d_address = tbl[n].da;
            d_wdata = tbl[n].dwd; d_byte_enable = tbl[n].dbe;
            mem_resp = tbl[n].mr; mem_rdata = tbl[n].mrd;
            @(negedge clk);
            check_all($sformatf("vec%0d", n), tbl[n].e_mr, tbl[n].e_mw, tbl[n].e_addr, tbl[n].e_be,
                      tbl[n].e_wd, tbl[n].e_ir, tbl[n].e_dr, tbl[n].mrd, tbl[n].e_busy, 1'b0);
        end

        // T4: D address change mid-transaction is ignored
        @(posedge clk); #1;
        d_read = 1'b1; d_address = 32'h100; d_byte_enable = 4'hF;
        @(negedge clk);
        chk("t4.idle_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            d_address = 32'h200 + 32'(k);
            @(negedge clk);
            chk("t4.mem_read", {31'd0, mem_read}, 32'd1);
            chk("t4.mem_address", mem_address, 32'h100);
        end
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("t4.d_resp", {31'd0, d_resp}, 32'd1);
        chk("t4.d_rdata", d_rdata, 32'h1357_9BDF);
        chk("t4.mem_address_end", mem_address, 32'h100);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("t4.mem_read_drop", {31'd0, mem_read}, 32'd0);

        // T5: watchdog trips after TMO stalled SERVE cycles and stays set
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 32'h400;
        @(negedge clk);
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("t5.busy%0d", k), {31'd0, busy}, 32'd1);
            chk($sformatf("t5.no_timeout%0d", k), {31'd0, timeout_err}, 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t5.timeout_set", {31'd0, timeout_err}, 32'd1);
            chk("t5.still_waiting", {31'd0, mem_read}, 32'd1);
        end
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 32'h2468_ACE0;
        @(negedge clk);
        chk("t5.i_resp", {31'd0, i_resp}, 32'd1);
        chk("t5.i_rdata", i_rdata, 32'h2468_ACE0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("t5.idle_busy", {31'd0, busy}, 32'd0);
        chk("t5.timeout_sticky", {31'd0, timeout_err}, 32'd1);

        // T6: asynchronous reset in the middle of a D write
        @(posedge clk); #1;
        d_write = 1'b1; d_address = 32'h500; d_wdata = 32'h0F0F_0F0F; d_byte_enable = 4'hC;
        @(negedge clk);
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        chk("t6.pre_write", {31'd0, mem_write}, 32'd1);
        chk("t6.pre_d_resp", {31'd0, d_resp}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6.mem_write", {31'd0, mem_write}, 32'd0);
        chk("t6.busy", {31'd0, busy}, 32'd0);
        chk("t6.d_resp", {31'd0, d_resp}, 32'd0);
        chk("t6.d_rdata", d_rdata, 32'h0);
        chk("t6.timeout_clr", {31'd0, timeout_err}, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 32'h600;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6.i_mem_read", {31'd0, mem_read}, 32'd1);
        chk("t6.i_mem_address", mem_address, 32'h600);
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 32'h600D_600D;
        @(negedge clk);
        chk("t6.i_resp", {31'd0, i_resp}, 32'd1);
        chk("t6.i_rdata", i_rdata, 32'h600D_600D);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("t6.idle", {31'd0, busy}, 32'd0);

        // Random traffic against a transaction-level model
        do_reset();
        owner = 0; last_was_d = 1'b0; m_wr = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wd = 32'h0;
        waited = 0; m_to = 1'b0; lat = 0; i_drop = 1'b0; d_drop = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (i_drop) begin
                i_read = 1'b0; i_drop = 1'b0;
            end else if (!i_read && ($urandom_range(0, 3) == 0)) begin
                i_read = 1'b1; i_address = $urandom & 32'hFFFF_FFFC;
            end
            if (d_drop) begin
                d_read = 1'b0; d_write = 1'b0; d_drop = 1'b0;
            end else if (!(d_read || d_write) && ($urandom_range(0, 3) == 0)) begin
                case ($urandom_range(0, 2))
                    0: begin d_read = 1'b1; d_write = 1'b0; end
                    1: begin d_read = 1'b0; d_write = 1'b1; end
                    default: begin d_read = 1'b1; d_write = 1'b1; end
                endcase
                d_address = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
                d_byte_enable = 4'($urandom_range(0, 15));
            end else if ((d_read || d_write) && ($urandom_range(0, 3) == 0)) begin
                d_address = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            if (owner != 0) begin
                if (lat == 0) mem_resp = 1'b1;
                else begin mem_resp = 1'b0; lat--; end
            end else begin
                mem_resp = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            check_all($sformatf("rnd%0d", cyc), (owner != 0) && !m_wr, (owner != 0) && m_wr,
                      m_addr, m_be, m_wd, (owner == 1) && mem_resp, (owner == 2) && mem_resp,
                      mem_rdata, owner != 0, m_to);
            if (owner == 0) begin
                if (i_read && (d_read || d_write)) side = last_was_d ? 1 : 2;
                else if (d_read || d_write) side = 2;
                else if (i_read) side = 1;
                else side = 0;
                if (side == 1) begin
                    m_wr = 1'b0; m_be = 4'h0; m_wd = 32'h0; m_addr = i_address;
                end else if (side == 2) begin
                    m_wr = d_write; m_be = d_byte_enable; m_wd = d_wdata; m_addr = d_address;
                end
                if (side != 0) begin
                    last_was_d = (side == 2); waited = 0; lat = $urandom_range(0, 4); owner = side;
                end
            end else if (mem_resp) begin
                if (owner == 1) i_drop = 1'b1;
                else d_drop = 1'b1;
                owner = 0;
            end else begin
                waited++;
                if (waited >= TMO) m_to = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
